// File: rtl/uart_tx_buffered.sv
// Buffered 8N1 UART transmitter: a small byte FIFO feeds a bit-serial shifter.
// Every output is a registered function of the FSM state, so the line lags the state by one cycle.
module uart_tx_buffered #(
  parameter int CLKS_PER_BIT = 87,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                          i_Clock,
  input  logic                          i_Rst_n,
  input  logic                          i_Tx_DV,
  input  logic [7:0]                    i_Tx_Byte,
  output logic                          o_Tx_Ready,
  output logic                          o_Tx_Overflow,
  output logic [$clog2(FIFO_DEPTH):0]   o_Fifo_Count,
  output logic                          o_Tx_Serial,
  output logic                          o_Tx_Active,
  output logic                          o_Tx_Done
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_LAST   = CW'(CLKS_PER_BIT - 1);
  localparam logic [AW:0]   COUNT_FULL = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, CLEANUP} state_t;

  state_t        state_reg, state_next;
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [AW:0]   count_reg;
  logic [7:0]    shift_reg, shift_next;
  logic [CW-1:0] clk_cnt_reg, clk_cnt_next;
  logic [2:0]    bit_idx_reg, bit_idx_next;
  logic          serial_reg, serial_next;
  logic          active_reg, active_next;
  logic          done_reg, done_next;
  logic          overflow_reg;
  logic          push, pop;

  // Ready looks only at the registered count, so a full FIFO refuses a write even on a pop cycle.
  assign o_Tx_Ready = (count_reg != COUNT_FULL);
  assign push       = i_Tx_DV && o_Tx_Ready;
  assign pop        = (state_reg == IDLE) && (count_reg != '0);

  always_ff @(posedge i_Clock) begin
    if (push) mem[wr_ptr_reg] <= i_Tx_Byte;
  end

  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      overflow_reg <= 1'b0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({push, pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
      overflow_reg <= i_Tx_DV && !o_Tx_Ready;
    end
  end

  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state_reg   <= IDLE;
      shift_reg   <= '0;
      clk_cnt_reg <= '0;
      bit_idx_reg <= '0;
      serial_reg  <= 1'b1;
      active_reg  <= 1'b0;
      done_reg    <= 1'b0;
    end else begin
      state_reg   <= state_next;
      shift_reg   <= shift_next;
      clk_cnt_reg <= clk_cnt_next;
      bit_idx_reg <= bit_idx_next;
      serial_reg  <= serial_next;
      active_reg  <= active_next;
      done_reg    <= done_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    shift_next   = shift_reg;
    clk_cnt_next = clk_cnt_reg;
    bit_idx_next = bit_idx_reg;
    serial_next  = 1'b1;
    active_next  = 1'b0;
    done_next    = 1'b0;
    case (state_reg)
      IDLE: begin
        if (pop) begin
          shift_next   = mem[rd_ptr_reg];
          clk_cnt_next = '0;
          bit_idx_next = '0;
          state_next   = START;
        end
      end
      START: begin
        serial_next = 1'b0;
        active_next = 1'b1;
        if (clk_cnt_reg == CNT_LAST) begin
          clk_cnt_next = '0;
          state_next   = DATA;
        end else begin
          clk_cnt_next = clk_cnt_reg + 1'b1;
        end
      end
      DATA: begin
        serial_next = shift_reg[bit_idx_reg];
        active_next = 1'b1;
        if (clk_cnt_reg == CNT_LAST) begin
          clk_cnt_next = '0;
          if (bit_idx_reg == 3'd7) state_next = STOP;
          else                     bit_idx_next = bit_idx_reg + 1'b1;
        end else begin
          clk_cnt_next = clk_cnt_reg + 1'b1;
        end
      end
      STOP: begin
        active_next = 1'b1;
        if (clk_cnt_reg == CNT_LAST) begin
          clk_cnt_next = '0;
          state_next   = CLEANUP;
        end else begin
          clk_cnt_next = clk_cnt_reg + 1'b1;
        end
      end
      CLEANUP: begin
        done_next  = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign o_Tx_Overflow = overflow_reg;
  assign o_Fifo_Count  = count_reg;
  assign o_Tx_Serial   = serial_reg;
  assign o_Tx_Active   = active_reg;
  assign o_Tx_Done     = done_reg;

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Bench for uart_tx_buffered: a timeline model (pop edge + frame offset) checked every cycle,
// a serial receiver model, and directed/random stimulus.
module tb_uart_tx_buffered;
  localparam int CPB   = 4;
  localparam int DEPTH = 4;
  localparam int FRAME = 10 * CPB;

  logic       i_Clock = 1'b0;
  logic       i_Rst_n = 1'b0;
  logic       i_Tx_DV = 1'b0;
  logic [7:0] i_Tx_Byte = 8'h00;
  logic       o_Tx_Ready, o_Tx_Overflow, o_Tx_Serial, o_Tx_Active, o_Tx_Done;
  logic [2:0] o_Fifo_Count;

  uart_tx_buffered #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .i_Clock(i_Clock), .i_Rst_n(i_Rst_n), .i_Tx_DV(i_Tx_DV), .i_Tx_Byte(i_Tx_Byte),
    .o_Tx_Ready(o_Tx_Ready), .o_Tx_Overflow(o_Tx_Overflow), .o_Fifo_Count(o_Fifo_Count),
    .o_Tx_Serial(o_Tx_Serial), .o_Tx_Active(o_Tx_Active), .o_Tx_Done(o_Tx_Done)
  );

  always #5 i_Clock = ~i_Clock;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a frame popped at edge P is visible after edges P+1..P+FRAME, Done after P+FRAME+1,
  // and the next pop may happen at edge P+FRAME+2.
  logic [7:0] mq[$];
  logic [7:0] done_q[$];
  logic [7:0] rx_q[$];
  logic [7:0] cur = 8'h00;
  int  edge_idx = 0;
  int  next_free = 0;
  int  pop_edge = 0;
  bit  in_frame = 1'b0;

  always @(posedge i_Clock) begin : model_cmp
    logic       dv_s, rst_s, exp_ser, exp_act, exp_done, exp_ovf;
    logic [7:0] b_s;
    int         k, bi, sz;
    dv_s = i_Tx_DV; b_s = i_Tx_Byte; rst_s = i_Rst_n;
    edge_idx++;
    exp_ser = 1'b1; exp_act = 1'b0; exp_done = 1'b0; exp_ovf = 1'b0;
    if (!rst_s) begin
      mq.delete();
      in_frame  = 1'b0;
      next_free = 0;
    end else begin
      sz = mq.size();
      exp_ovf = dv_s && (sz == DEPTH);
      if (sz > 0 && edge_idx >= next_free) begin
        cur       = mq.pop_front();
        pop_edge  = edge_idx;
        in_frame  = 1'b1;
        next_free = edge_idx + FRAME + 2;
      end
      if (dv_s && sz != DEPTH) mq.push_back(b_s);
      if (in_frame) begin
        k = edge_idx - pop_edge;
        if (k >= 1 && k <= FRAME) begin
          exp_act = 1'b1;
          bi = (k - 1) / CPB;
          if (bi == 0)      exp_ser = 1'b0;
          else if (bi <= 8) exp_ser = cur[bi-1];
        end
        if (k == FRAME + 1) begin
          exp_done = 1'b1;
          done_q.push_back(cur);
          in_frame = 1'b0;
        end
      end
    end
    #1;
    check("serial",   32'(o_Tx_Serial),   32'(exp_ser));
    check("active",   32'(o_Tx_Active),   32'(exp_act));
    check("done",     32'(o_Tx_Done),     32'(exp_done));
    check("overflow", 32'(o_Tx_Overflow), 32'(exp_ovf));
    check("count",    32'(o_Fifo_Count),  32'(mq.size()));
    check("ready",    32'(o_Tx_Ready),    32'(mq.size() != DEPTH));
  end

  // Receiver model: mid-bit sampling; a frame touched by reset is discarded.
  bit rx_ok = 1'b0;
  task automatic rx_wait(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge i_Clock);
      if (!i_Rst_n) rx_ok = 1'b0;
    end
  endtask

  initial begin : rx_model
    logic [7:0] rb;
    rb = 8'h00;
    forever begin
      @(negedge i_Clock);
      if (i_Rst_n === 1'b1 && o_Tx_Serial === 1'b0) begin
        rx_ok = 1'b1;
        rx_wait(CPB / 2);
        for (int b = 0; b < 8; b++) begin
          rx_wait(CPB);
          rb[b] = o_Tx_Serial;
        end
        rx_wait(CPB);
        if (o_Tx_Serial !== 1'b1) rx_ok = 1'b0;
        if (rx_ok) rx_q.push_back(rb);
      end
    end
  end

  task automatic wait_done(input int budget, output int act_cyc, output bit seen);
    act_cyc = 0;
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge i_Clock);
      if (o_Tx_Active) act_cyc++;
      if (o_Tx_Done) seen = 1'b1;
    end
    if (!seen) check("done_timeout", 32'd0, 32'd1);
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : driver
    int  act_cyc, dones, bad, low_seen;
    bit  seen;
    repeat (3) @(negedge i_Clock);
    i_Rst_n = 1'b1;
    @(negedge i_Clock);
    check("rst_ready",  32'(o_Tx_Ready),   32'd1);
    check("rst_count",  32'(o_Fifo_Count), 32'd0);
    check("rst_serial", 32'(o_Tx_Serial),  32'd1);

    // Single byte 0x55: latency and frame length.
    i_Tx_DV = 1'b1; i_Tx_Byte = 8'h55;
    @(posedge i_Clock); #1;
    check("lat_count_push", 32'(o_Fifo_Count), 32'd1);
    @(negedge i_Clock); i_Tx_DV = 1'b0;
    @(posedge i_Clock); #1;
    check("lat_count_pop", 32'(o_Fifo_Count), 32'd0);
    check("lat_serial_n1", 32'(o_Tx_Serial),  32'd1);
    @(posedge i_Clock); #1;
    check("lat_serial_n2", 32'(o_Tx_Serial),  32'd0);
    check("lat_active_n2", 32'(o_Tx_Active),  32'd1);
    wait_done(200, act_cyc, seen);
    check("active_len_55", 32'(act_cyc), 32'(FRAME));
    @(negedge i_Clock);
    check("rx_55", 32'(rx_q.size() > 0 ? rx_q[rx_q.size()-1] : 8'h00), 32'h55);

    // 0xA3 through the receiver model.
    i_Tx_DV = 1'b1; i_Tx_Byte = 8'hA3;
    @(negedge i_Clock); i_Tx_DV = 1'b0; i_Tx_Byte = 8'h5C;
    wait_done(200, act_cyc, seen);
    check("rx_A3", 32'(rx_q.size() > 0 ? rx_q[rx_q.size()-1] : 8'h00), 32'hA3);
    repeat (3) @(negedge i_Clock);

    // Burst of 5 into a depth-4 FIFO with the FSM idle.
    for (int i = 1; i <= 5; i++) begin
      check("burst_ready", 32'(o_Tx_Ready), 32'd1);
      i_Tx_DV = 1'b1; i_Tx_Byte = 8'(i);
      @(negedge i_Clock);
    end
    i_Tx_DV = 1'b0;
    dones = 0;
    wait_done(200, act_cyc, seen);
    if (seen) dones++;
    @(negedge i_Clock);
    check("gap_idle2",  32'(o_Tx_Serial), 32'd1);
    @(negedge i_Clock);
    check("gap_start",  32'(o_Tx_Serial), 32'd0);
    for (int i = 0; i < 4; i++) begin
      wait_done(100, act_cyc, seen);
      if (seen) dones++;
    end
    check("burst_dones", 32'(dones), 32'd5);
    for (int i = 0; i < 5; i++)
      check("burst_rx", 32'(rx_q.size() >= 5 ? rx_q[rx_q.size()-5+i] : 8'h00), 32'(i + 1));
    repeat (3) @(negedge i_Clock);

    // Overflow while a frame is in flight, then push on the full pop cycle.
    for (int i = 0; i < 5; i++) begin
      i_Tx_DV = 1'b1; i_Tx_Byte = 8'(8'h10 + i);
      @(negedge i_Clock);
    end
    check("full_ready", 32'(o_Tx_Ready), 32'd0);
    i_Tx_Byte = 8'hEE;
    @(posedge i_Clock); #1;
    check("ovf_pulse", 32'(o_Tx_Overflow), 32'd1);
    check("ovf_count", 32'(o_Fifo_Count),  32'd4);
    @(negedge i_Clock); i_Tx_DV = 1'b0;
    @(posedge i_Clock); #1;
    check("ovf_clear", 32'(o_Tx_Overflow), 32'd0);
    wait_done(200, act_cyc, seen);
    i_Tx_DV = 1'b1; i_Tx_Byte = 8'hDD;
    @(posedge i_Clock); #1;
    check("simul_ovf",   32'(o_Tx_Overflow), 32'd1);
    check("simul_count", 32'(o_Fifo_Count),  32'd3);
    @(negedge i_Clock); i_Tx_DV = 1'b0;
    for (int i = 0; i < 4; i++) wait_done(100, act_cyc, seen);
    for (int i = 0; i < 5; i++)
      check("ovf_rx", 32'(rx_q.size() >= 5 ? rx_q[rx_q.size()-5+i] : 8'h00), 32'(8'h10 + i));
    repeat (3) @(negedge i_Clock);

    // Reset mid-frame with bytes still queued.
    for (int i = 0; i < 3; i++) begin
      i_Tx_DV = 1'b1; i_Tx_Byte = 8'(8'h77 + i);
      @(negedge i_Clock);
    end
    i_Tx_DV = 1'b0;
    repeat (15) @(negedge i_Clock);
    #1 i_Rst_n = 1'b0;
    #1;
    check("arst_serial", 32'(o_Tx_Serial),  32'd1);
    check("arst_active", 32'(o_Tx_Active),  32'd0);
    check("arst_count",  32'(o_Fifo_Count), 32'd0);
    check("arst_ready",  32'(o_Tx_Ready),   32'd1);
    repeat (6) @(negedge i_Clock);
    i_Rst_n = 1'b1;
    dones = 0; low_seen = 0;
    repeat (60) begin
      @(negedge i_Clock);
      if (o_Tx_Done) dones++;
      if (!o_Tx_Serial) low_seen++;
    end
    check("arst_no_done", 32'(dones),    32'd0);
    check("arst_no_tx",   32'(low_seen), 32'd0);

    // Random traffic: sparse, then dense enough to overflow.
    for (int c = 0; c < 700; c++) begin
      i_Tx_DV   = ($urandom_range(0, 99) < (c < 350 ? 4 : 30));
      i_Tx_Byte = 8'($urandom);
      @(negedge i_Clock);
    end
    i_Tx_DV = 1'b0;
    repeat (6 * (FRAME + 2) + 20) @(negedge i_Clock);

    check("rx_total", 32'(rx_q.size()), 32'(done_q.size()));
    for (int i = 0; i < rx_q.size() && i < done_q.size(); i++)
      check("rx_byte", 32'(rx_q[i]), 32'(done_q[i]));
    bad = 0;
    foreach (rx_q[i]) if (rx_q[i] == 8'hEE || rx_q[i] == 8'hDD) bad++;
    check("dropped_never_sent", 32'(bad), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
